mat_vec_seq: RTL and testbench
==============================

Name: mat_vec_seq

Overview:
- Sequences one 4x4 matrix × 4-vector transform (vertex transform) through a single shared 4-element dot-product unit.
- The block sits in front of the dot-product unit and also consumes its output:
  - presents one matrix row plus the vector per cycle;
  - collects the four scalar results after the unit's fixed pipeline latency;
  - emits the transformed vector with a valid/ready handshake.
- Arithmetic format (integer or fixed-point) is handled entirely by the dot-product unit; this block is format-agnostic.

Parameters:
- WIDTH, 32, bit width of every matrix element, vector element and result element.
- DP_LATENCY, 3, cycles from dot-product inputs being driven to the matching dp_out value (≥1).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- matrix_in  input  16*WIDTH  row-major matrix; element m[r][c] at bits [WIDTH*(4r+c) +: WIDTH].
- vec_in  input  4*WIDTH  vector; element c at bits [WIDTH*c +: WIDTH].
- vec_valid_in  input  1  matrix_in/vec_in valid.
- vec_ready_out  output  1  block can accept a new job.
- dp_x_out  output  4*WIDTH  current matrix row to dot-product unit.
- dp_y_out  output  4*WIDTH  captured vector to dot-product unit.
- dp_in  input  WIDTH  dot-product unit result.
- result_out  output  4*WIDTH  transformed vector; row r result at [WIDTH*r +: WIDTH].
- result_valid_out  output  1  result_out valid.
- result_ready_in  input  1  downstream accepts result.

Behaviour:
- Clock and reset:
  - Single clock clk_in.
  - rst_in is synchronous and active-high.
- Reset values:
  - vec_ready_out=1, result_valid_out=0, result_out=0, dp_x_out=0, dp_y_out=0.
  - FSM goes to IDLE; row counter and tag pipe are cleared.
- States:
  - IDLE:
    - vec_ready_out=1.
    - Accept on vec_valid_in && vec_ready_out: register the full matrix and vector, go to ISSUE with row=0.
  - ISSUE:
    - Cycle k (k=0..3): dp_x_out = captured row k, dp_y_out = captured vector.
    - Push tag {valid=1,row=k} into a DP_LATENCY-deep shift pipe.
    - After row 3, go to DRAIN.
  - DRAIN:
    - dp_x_out/dp_y_out are driven to 0; pipe shifts in invalid tags.
    - When the pipe-output tag is valid, write dp_in into result slot [tag.row].
    - When row 3 has been written, go to DONE.
  - DONE:
    - result_valid_out=1 and result_out is held stable.
    - On result_ready_in, go to IDLE; vec_ready_out rises the next cycle.
- dp_in sampling:
  - dp_in is sampled with the pipe-output tag in every state, including the last ISSUE cycles when DP_LATENCY < 4.
  - The inputs driven in cycle t are paired with dp_in in cycle t+DP_LATENCY.
- Latency:
  - Accept edge at cycle 0; rows are driven in cycles 1..4.
  - Row 3 result is captured at the end of cycle 4+DP_LATENCY.
  - result_valid_out is high from cycle 5+DP_LATENCY, i.e. cycle 8 for the default.
- Throughput:
  - One job per 6+DP_LATENCY cycles when result_ready_in is held high.
  - No overlap of jobs.
- Boundary conditions:
  - vec_valid_in outside IDLE is ignored; vec_ready_out=0 there, and inputs are not sampled.
  - result_ready_in low in DONE: stall indefinitely, outputs stable, no new accept.
  - result_ready_in high before DONE has no effect.
  - Input changes after accept do not affect the running job, which uses registered copies.
  - Reset mid-job:
    - Next cycle is IDLE with all reset values.
    - In-flight dot-product results are discarded via the cleared tag pipe.
    - No spurious result_valid_out.
  - Results wrap per dot-product unit semantics; no saturation here.

Optional Feature:
- Macro: AFFINE_FAST_EN.
- Defined:
  - Matrix row 3 is treated as (0,0,0,1).
  - Only rows 0..2 are issued.
  - result slot 3 is loaded with captured vec element 3 at accept.
  - result_valid_out rises at cycle 4+DP_LATENCY (7 for default).
- Undefined: all four rows are issued as described above.

Test Plan:
- Identity matrix, vec=(1,2,3,4), dot-product unit integer mode, ready high:
  - result_out=(1,2,3,4);
  - result_valid_out first high exactly 8 cycles after the accept edge (7 with AFFINE_FAST_EN).
- Matrix rows (1,2,3,4),(5,6,7,8),(9,10,11,12),(13,14,15,16), vec=(1,1,1,1) -> result=(10,26,42,58).
- Same job with result_ready_in held low 5 cycles after valid:
  - result held (10,26,42,58);
  - vec_ready_out stays 0 and a vec_valid_in pulse is ignored;
  - IDLE is reached one cycle after ready rises.
- rst_in asserted during ISSUE row 2, then a new job (identity, vec=(7,7,7,7)):
  - no result_valid_out from the aborted job;
  - result=(7,7,7,7) at the normal latency.
- Back-to-back jobs with valid and ready always high, second job matrix=2×identity, vec=(−1,3,0,5):
  - results (1,2,3,4) then (−2,6,0,10);
  - accepts are 9 cycles apart.
- DP_LATENCY=1 build with rows issued back-to-back: every row result lands in the correct slot, matching scenario 2's expected vector.

Source files
------------

// File: rtl/mat_vec_seq.sv
// mat_vec_seq: runs one 4x4 matrix x 4-vector transform through a single
// shared 4-element dot-product unit, then presents the result vector on a
// valid/ready handshake. The block never does arithmetic itself, so it works
// for any number format the dot-product unit understands.
//
// Optional build macro AFFINE_FAST_EN: treat matrix row 3 as (0,0,0,1),
// issue only rows 0..2 and load result slot 3 straight from vector element 3.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   matrix_in             row-major matrix, m[r][c] at [WIDTH*(4r+c) +: WIDTH]
//   vec_in                vector, element c at [WIDTH*c +: WIDTH]
//   vec_valid_in/out      job handshake (vec_ready_out high only in IDLE)
//   dp_x_out, dp_y_out    current matrix row / captured vector to the unit
//   dp_in                 unit result, DP_LATENCY cycles after its inputs
//   result_out            row r result at [WIDTH*r +: WIDTH]
//   result_valid_out/ready_in  result handshake
//
// state | meaning
// IDLE  | ready for a new job
// ISSUE | one matrix row per cycle on dp_x_out
// DRAIN | dp inputs zero, waiting for the last row's result
// DONE  | result_out valid and held until result_ready_in
module mat_vec_seq #(
  parameter int WIDTH      = 32,
  parameter int DP_LATENCY = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [16*WIDTH-1:0] matrix_in,
  input  logic [4*WIDTH-1:0]  vec_in,
  input  logic                vec_valid_in,
  output logic                vec_ready_out,
  output logic [4*WIDTH-1:0]  dp_x_out,
  output logic [4*WIDTH-1:0]  dp_y_out,
  input  logic [WIDTH-1:0]    dp_in,
  output logic [4*WIDTH-1:0]  result_out,
  output logic                result_valid_out,
  input  logic                result_ready_in
);

`ifdef AFFINE_FAST_EN
  localparam logic [1:0] LAST_ROW = 2'd2;
`else
  localparam logic [1:0] LAST_ROW = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] row;
  } tag_t;

  state_e              state_q;
  logic [16*WIDTH-1:0] mat_q;
  logic [1:0]          row_q;        // row currently on dp_x_out
  logic                issue_vld_q;  // dp_x_out/dp_y_out carry a real row
  tag_t                pipe_q [DP_LATENCY];
  logic [WIDTH-1:0]    res_q [4];
  logic                vec_ready_q;
  logic                result_valid_q;
  logic [4*WIDTH-1:0]  dp_x_q;
  logic [4*WIDTH-1:0]  dp_y_q;

  logic [1:0]          row_nxt_d;
  logic [4*WIDTH-1:0]  row_sel_d;
  tag_t                tag_out;

  assign row_nxt_d = row_q + 2'd1;
  assign row_sel_d = mat_q[4*WIDTH*row_nxt_d +: 4*WIDTH];
  // Tag leaving the pipe describes the inputs that produced the current dp_in.
  assign tag_out   = pipe_q[DP_LATENCY-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      mat_q          <= '0;
      row_q          <= '0;
      issue_vld_q    <= 1'b0;
      vec_ready_q    <= 1'b1;
      result_valid_q <= 1'b0;
      dp_x_q         <= '0;
      dp_y_q         <= '0;
      for (int i = 0; i < DP_LATENCY; i++) pipe_q[i] <= '0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      // Tag pipe runs in every state so late rows land even after ISSUE ends.
      pipe_q[0] <= '{vld: issue_vld_q, row: row_q};
      for (int i = 1; i < DP_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      if (tag_out.vld) res_q[tag_out.row] <= dp_in;

      case (state_q)
        IDLE: begin
          if (vec_valid_in) begin
            mat_q       <= matrix_in;
            dp_x_q      <= matrix_in[0 +: 4*WIDTH];
            dp_y_q      <= vec_in;
            row_q       <= 2'd0;
            issue_vld_q <= 1'b1;
            vec_ready_q <= 1'b0;
            state_q     <= ISSUE;
`ifdef AFFINE_FAST_EN
            res_q[3]    <= vec_in[3*WIDTH +: WIDTH];
`endif
          end
        end
        ISSUE: begin
          if (row_q == LAST_ROW) begin
            dp_x_q      <= '0;
            dp_y_q      <= '0;
            issue_vld_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            row_q  <= row_nxt_d;
            dp_x_q <= row_sel_d;
          end
        end
        DRAIN: begin
          if (tag_out.vld && (tag_out.row == LAST_ROW)) begin
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (result_ready_in) begin
            result_valid_q <= 1'b0;
            vec_ready_q    <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_ready_out    = vec_ready_q;
  assign result_valid_out = result_valid_q;
  assign dp_x_out         = dp_x_q;
  assign dp_y_out         = dp_y_q;
  assign result_out       = {res_q[3], res_q[2], res_q[1], res_q[0]};

endmodule

// File: tb/tb_mat_vec_seq.sv
// Bench for mat_vec_seq: two instances (DP_LATENCY 3 and 1), each fed by a
// behavioural integer dot-product unit, checked against a matrix-vector
// product computed directly from the input matrix and vector.
module tb_mat_vec_seq;
  localparam int W   = 32;
  localparam int LAT = 3;
`ifdef AFFINE_FAST_EN
  localparam bit AFF = 1'b1;
`else
  localparam bit AFF = 1'b0;
`endif
  localparam int EXP_LAT  = AFF ? 4 + LAT : 5 + LAT;
  localparam int EXP_LAT1 = AFF ? 5 : 6;

  logic            clk = 1'b0;
  logic            rst_in;
  logic [16*W-1:0] matrix_in;
  logic [4*W-1:0]  vec_in;
  logic            vec_valid_in, result_ready_in;
  logic            vec_ready_out, result_valid_out;
  logic [4*W-1:0]  dp_x_out, dp_y_out, result_out;
  logic [W-1:0]    dp_in;

  logic            v1_valid, r1_ready;
  logic            v1_ready, res1_valid;
  logic [4*W-1:0]  dp_x1, dp_y1, result1;
  logic [W-1:0]    dp_in1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_vec_seq #(.WIDTH(W), .DP_LATENCY(LAT)) u_dut (
    .clk_in(clk), .rst_in(rst_in), .matrix_in(matrix_in), .vec_in(vec_in),
    .vec_valid_in(vec_valid_in), .vec_ready_out(vec_ready_out),
    .dp_x_out(dp_x_out), .dp_y_out(dp_y_out), .dp_in(dp_in),
    .result_out(result_out), .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in));

  mat_vec_seq #(.WIDTH(W), .DP_LATENCY(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst_in), .matrix_in(matrix_in), .vec_in(vec_in),
    .vec_valid_in(v1_valid), .vec_ready_out(v1_ready),
    .dp_x_out(dp_x1), .dp_y_out(dp_y1), .dp_in(dp_in1),
    .result_out(result1), .result_valid_out(res1_valid),
    .result_ready_in(r1_ready));

  // Integer-mode dot-product unit with fixed latency.
  function automatic logic [W-1:0] dot(input logic [4*W-1:0] x, input logic [4*W-1:0] y);
    logic [W-1:0] s;
    s = '0;
    for (int c = 0; c < 4; c++) s += x[W*c +: W] * y[W*c +: W];
    return s;
  endfunction

  logic [W-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dot(dp_x_out, dp_y_out);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_in = dp_pipe[LAT-1];

  logic [W-1:0] dp_pipe1;
  always @(posedge clk) dp_pipe1 <= dot(dp_x1, dp_y1);
  assign dp_in1 = dp_pipe1;

  // Reference: result[r] = sum_c m[r][c]*v[c], wrapping at W bits.
  function automatic logic [4*W-1:0] ref_mv(input logic [16*W-1:0] m, input logic [4*W-1:0] v);
    logic [4*W-1:0] r;
    logic [W-1:0]   acc;
    for (int row = 0; row < 4; row++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) acc += m[W*(4*row+c) +: W] * v[W*c +: W];
      r[W*row +: W] = acc;
    end
    if (AFF) r[W*3 +: W] = v[W*3 +: W];
    return r;
  endfunction

  function automatic logic [4*W-1:0] vec4(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [16*W-1:0] ident(input logic [W-1:0] k);
    logic [16*W-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[W*(5*i) +: W] = k;
    return m;
  endfunction

  function automatic logic [16*W-1:0] count_mat();
    logic [16*W-1:0] m;
    for (int i = 0; i < 16; i++) m[W*i +: W] = W'(i + 1);
    return m;
  endfunction

  function automatic logic [16*W-1:0] rand_mat();
    logic [16*W-1:0] m;
    for (int i = 0; i < 16; i++) m[W*i +: W] = $urandom;
    return m;
  endfunction

  function automatic logic [4*W-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; optionally stalls the result.
  task automatic run_job(input logic [16*W-1:0] m, input logic [4*W-1:0] v,
                         input string tag, input int hold);
    logic [4*W-1:0] exp, held;
    int k;
    exp = ref_mv(m, v);
    matrix_in = m;
    vec_in = v;
    vec_valid_in = 1'b1;
    result_ready_in = (hold == 0);
    chk({tag, "_rdy"}, vec_ready_out, 1);
    @(negedge clk);
    k = 1;
    vec_valid_in = 1'b0;
    matrix_in = rand_mat();
    vec_in = rand_vec();
    chk({tag, "_busy"}, vec_ready_out, 0);
    while (!result_valid_out && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, EXP_LAT);
    chk({tag, "_res"}, result_out, exp);
    held = result_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_res"}, result_out, held);
      chk({tag, "_hold_vld"}, result_valid_out, 1);
      chk({tag, "_hold_rdy"}, vec_ready_out, 0);
      if (i == 1) begin
        vec_valid_in = 1'b1;
        matrix_in = rand_mat();
      end
      if (i == 2) vec_valid_in = 1'b0;
    end
    vec_valid_in = 1'b0;
    result_ready_in = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, vec_ready_out, 1);
    chk({tag, "_idle_vld"}, result_valid_out, 0);
  endtask

  initial begin
    logic [16*W-1:0] m;
    logic [4*W-1:0]  exp_b2b [2];
    int acc_t [2];
    int acc_cnt, res_cnt, guard, k, spurious;

    rst_in = 1'b1;
    matrix_in = '0;
    vec_in = '0;
    vec_valid_in = 1'b0;
    result_ready_in = 1'b0;
    v1_valid = 1'b0;
    r1_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", vec_ready_out, 1);
    chk("rst_vld", result_valid_out, 0);
    chk("rst_res", result_out, 0);
    chk("rst_dpx", dp_x_out, 0);
    chk("rst_dpy", dp_y_out, 0);
    rst_in = 1'b0;
    @(negedge clk);

    run_job(ident(1), vec4(1, 2, 3, 4), "ident", 0);
    chk("ident_lit", result_out, vec4(1, 2, 3, 4));
    run_job(count_mat(), vec4(1, 1, 1, 1), "count", 0);
    if (!AFF) chk("count_lit", result_out, vec4(10, 26, 42, 58));
    run_job(count_mat(), vec4(1, 1, 1, 1), "stall", 5);
    for (int j = 0; j < 4; j++) run_job(rand_mat(), rand_vec(), "rand", j % 2);

    // Reset while row 2 is on the dot-product inputs.
    m = rand_mat();
    matrix_in = m;
    vec_in = rand_vec();
    vec_valid_in = 1'b1;
    @(negedge clk);
    vec_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_row2", dp_x_out, m[4*W*2 +: 4*W]);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    chk("abort_rdy", vec_ready_out, 1);
    chk("abort_vld", result_valid_out, 0);
    chk("abort_res", result_out, 0);
    chk("abort_dpx", dp_x_out, 0);
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (result_valid_out) spurious++;
      @(negedge clk);
    end
    chk("abort_spurious", spurious, 0);
    run_job(ident(1), vec4(7, 7, 7, 7), "after_rst", 0);

    // Back-to-back jobs with valid and ready held high.
    exp_b2b[0] = ref_mv(ident(1), vec4(1, 2, 3, 4));
    exp_b2b[1] = ref_mv(ident(2), vec4(-1, 3, 0, 5));
    acc_t[0] = 0;
    acc_t[1] = 0;
    acc_cnt = 0;
    res_cnt = 0;
    guard = 0;
    matrix_in = ident(1);
    vec_in = vec4(1, 2, 3, 4);
    vec_valid_in = 1'b1;
    result_ready_in = 1'b1;
    while ((acc_cnt < 2 || res_cnt < 2) && guard < 60) begin
      if (vec_ready_out && vec_valid_in && acc_cnt < 2) begin
        acc_t[acc_cnt] = cyc;
        acc_cnt++;
      end
      if (result_valid_out && res_cnt < 2) begin
        chk("b2b_res", result_out, exp_b2b[res_cnt]);
        res_cnt++;
      end
      @(negedge clk);
      guard++;
      if (acc_cnt == 1) begin
        matrix_in = ident(2);
        vec_in = vec4(-1, 3, 0, 5);
      end
      if (acc_cnt == 2) vec_valid_in = 1'b0;
    end
    chk("b2b_count", {acc_cnt[15:0], res_cnt[15:0]}, {16'd2, 16'd2});
    chk("b2b_gap", acc_t[1] - acc_t[0], EXP_LAT + 1);
    chk("b2b_lit", exp_b2b[1], vec4(-2, 6, 0, 10));
    vec_valid_in = 1'b0;
    repeat (12) @(negedge clk);

    // DP_LATENCY=1 instance: rows issued back-to-back with one-cycle returns.
    matrix_in = count_mat();
    vec_in = vec4(1, 1, 1, 1);
    v1_valid = 1'b1;
    r1_ready = 1'b1;
    chk("lat1_rdy", v1_ready, 1);
    @(negedge clk);
    v1_valid = 1'b0;
    k = 1;
    while (!res1_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("lat1_lat", k, EXP_LAT1);
    chk("lat1_res", result1, ref_mv(count_mat(), vec4(1, 1, 1, 1)));
    @(negedge clk);
    chk("lat1_idle", v1_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
